// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ID/EX control-bit layout, ALUOp and funct
// encodings, and the internal ALU control codes.
package mips_pkg;

   localparam int CB_REGWRITE = 8;
   localparam int CB_MEMTOREG = 7;
   localparam int CB_BRANCH   = 6;
   localparam int CB_MEMREAD  = 5;
   localparam int CB_MEMWRITE = 4;
   localparam int CB_REGDST   = 3;
   localparam int CB_ALUOP_HI = 2;
   localparam int CB_ALUOP_LO = 1;
   localparam int CB_ALUSRC   = 0;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_NONE  = 2'b11
   } aluop_e;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   // ALU_ZERO is an internal code for unsupported operations (result forced to 0).
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_NOR  = 4'b1100,
      ALU_ZERO = 4'b1111
   } alu_ctrl_e;

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational ALU control decode (ALUOp + funct) and the ALU itself.
module alu_ctrl_alu
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        alu_op_i,
   input  logic [5:0]        funct_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o
);

   alu_ctrl_e ctrl;

   always_comb begin
      ctrl = ALU_ZERO;
      case (alu_op_i)
         ALUOP_ADD:   ctrl = ALU_ADD;
         ALUOP_SUB:   ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               FN_ADD:  ctrl = ALU_ADD;
               FN_SUB:  ctrl = ALU_SUB;
               FN_AND:  ctrl = ALU_AND;
               FN_OR:   ctrl = ALU_OR;
               FN_SLT:  ctrl = ALU_SLT;
               FN_NOR:  ctrl = ALU_NOR;
               default: ctrl = ALU_ZERO;
            endcase
         end
         default:     ctrl = ALU_ZERO;
      endcase
   end

   always_comb begin
      result_o = '0;
      case (ctrl)
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_NOR: result_o = ~(a_i | b_i);
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand/destination muxes, ALU, branch target adder and
// the EX/MEM pipeline register with bubble (flush) and hold (stall) control.
module ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [8:0]        control_bits_in,
   input  logic [DATA_W-1:0] npc_in,
   input  logic [DATA_W-1:0] read_data_1,
   input  logic [DATA_W-1:0] read_data_2,
   input  logic [DATA_W-1:0] sign_ext,
   input  logic [REG_AW-1:0] rt_in,
   input  logic [REG_AW-1:0] rd_in,
   input  logic              flush,
   input  logic              stall,
   output logic [1:0]        ex_mem_wb,
   output logic [2:0]        ex_mem_m,
   output logic [DATA_W-1:0] ex_mem_branch_target,
   output logic              ex_mem_zero,
   output logic [DATA_W-1:0] ex_mem_alu_result,
   output logic [DATA_W-1:0] ex_mem_write_data,
   output logic [REG_AW-1:0] ex_mem_write_reg,
   output logic              ex_mem_valid
);

   logic [DATA_W-1:0] alu_b;
   logic [REG_AW-1:0] dest;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic [DATA_W-1:0] branch_target;
   logic [1:0]        wb_d;
   logic [2:0]        m_d;

   logic [1:0]        wb_q;
   logic [2:0]        m_q;
   logic [DATA_W-1:0] target_q;
   logic              zero_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] wdata_q;
   logic [REG_AW-1:0] wreg_q;
   logic              valid_q;

   assign alu_b = control_bits_in[CB_ALUSRC] ? sign_ext : read_data_2;
   assign dest  = control_bits_in[CB_REGDST] ? rd_in : rt_in;
   // Shifting within DATA_W drops the top two immediate bits; the add wraps.
   assign branch_target = npc_in + (sign_ext << 2);
   assign wb_d = {control_bits_in[CB_REGWRITE], control_bits_in[CB_MEMTOREG]};
   assign m_d  = {control_bits_in[CB_BRANCH], control_bits_in[CB_MEMREAD],
                  control_bits_in[CB_MEMWRITE]};

   alu_ctrl_alu #(.DATA_W(DATA_W)) u_alu (
      .alu_op_i (control_bits_in[CB_ALUOP_HI:CB_ALUOP_LO]),
      .funct_i  (sign_ext[5:0]),
      .a_i      (read_data_1),
      .b_i      (alu_b),
      .result_o (alu_result),
      .zero_o   (alu_zero)
   );

   // Flush beats stall: a bubble must land even while MEM asks to hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_q     <= '0;
         m_q      <= '0;
         target_q <= '0;
         zero_q   <= 1'b0;
         result_q <= '0;
         wdata_q  <= '0;
         wreg_q   <= '0;
         valid_q  <= 1'b0;
      end else if (flush || !stall) begin
         wb_q     <= flush ? 2'b00 : wb_d;
         m_q      <= flush ? 3'b000 : m_d;
         valid_q  <= !flush;
         target_q <= branch_target;
         zero_q   <= alu_zero;
         result_q <= alu_result;
         wdata_q  <= read_data_2;
         wreg_q   <= dest;
      end
   end

   assign ex_mem_wb            = wb_q;
   assign ex_mem_m             = m_q;
   assign ex_mem_branch_target = target_q;
   assign ex_mem_zero          = zero_q;
   assign ex_mem_alu_result    = result_q;
   assign ex_mem_write_data    = wdata_q;
   assign ex_mem_write_reg     = wreg_q;
   assign ex_mem_valid         = valid_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the five-stage MIPS datapath, and the consumer of everything the ID stage drives into ID/EX.
- Decodes ALU control from ALUOp plus the funct field. Selects the ALU B operand and the destination register, computes the ALU result, the zero flag and the branch target.
- Captures all results into the EX/MEM pipeline register, which has flush (bubble) and stall (hold) control.
- Outputs feed the MEM stage; the branch target and zero flag also return to IF via MEM.

Parameters:
- DATA_W, 32, datapath and address width.
- REG_AW, 5, register specifier width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- control_bits_in  in  9  ID/EX control bits. [8] RegWrite, [7] MemtoReg, [6] Branch, [5] MemRead, [4] MemWrite, [3] RegDst, [2:1] ALUOp, [0] ALUSrc.
- npc_in  in  DATA_W  PC+4 from ID/EX.
- read_data_1  in  DATA_W  rs value, ALU A operand.
- read_data_2  in  DATA_W  rt value, ALU B candidate and store data.
- sign_ext  in  DATA_W  sign-extended immediate; bits [5:0] are funct.
- rt_in  in  REG_AW  instr[20:16].
- rd_in  in  REG_AW  instr[15:11].
- flush  in  1  PCSrc from MEM: insert a bubble.
- stall  in  1  hold the EX/MEM register.
- ex_mem_wb  out  2  {RegWrite, MemtoReg}.
- ex_mem_m  out  3  {Branch, MemRead, MemWrite}.
- ex_mem_branch_target  out  DATA_W  npc_in + (sign_ext << 2).
- ex_mem_zero  out  1  ALU result == 0.
- ex_mem_alu_result  out  DATA_W  ALU result.
- ex_mem_write_data  out  DATA_W  read_data_2 passthrough.
- ex_mem_write_reg  out  REG_AW  destination register.
- ex_mem_valid  out  1  the slot holds a real instruction.

Behaviour:
- Combinational front end:
  - B = ALUSrc ? sign_ext : read_data_2.
  - dest = RegDst ? rd_in : rt_in.
- ALU control:
  - ALUOp 00 → ADD.
  - ALUOp 01 → SUB.
  - ALUOp 10 → by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR; any other funct → result 0.
  - ALUOp 11 → result 0.
- Arithmetic:
  - ADD/SUB modulo 2^DATA_W; no overflow trap.
  - SLT is a signed compare producing 1 or 0, zero-extended.
  - Branch target adder is modulo 2^DATA_W; the shift drops sign_ext[31:30].
- Register update on posedge clk, priority reset > flush > stall > load:
  - reset=0: every output cleared to 0, including ex_mem_valid.
  - flush=1: ex_mem_wb, ex_mem_m and ex_mem_valid cleared to 0; datapath fields load normally (don't-care).
  - stall=1 (no flush): all outputs hold.
  - Otherwise: load all fields, ex_mem_valid=1.
- Latency: exactly 1 cycle from ID/EX inputs to EX/MEM outputs; throughput 1 per cycle.
- flush and stall both high: flush wins; a bubble is written.
- Reset mid-stream: the next cycle after reset deassertion loads fresh inputs; no stale state survives.
- All-zero control_bits_in (NOP) still loads; valid=1, wb and m = 0.

Decomposition:
- Shared package mips_pkg holds:
  - control-bit index constants (CB_REGWRITE=8 … CB_ALUSRC=0);
  - ALUOp encodings;
  - funct codes;
  - 4-bit ALU control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- One sub-module, alu_ctrl_alu: combinational ALU control plus ALU, returning result and zero.
- The EX/MEM register and muxes stay in ex_stage.

Test Plan:
1. R-type add: ALUOp=10, funct=100000, A=7, rd_data2=5, RegDst=1, rt=9, rd=10 → next edge alu_result=12, write_reg=10, zero=0, valid=1.
2. beq path: ALUOp=01, A=B=0x1234, npc_in=0x100, sign_ext=0x4, Branch=1 → zero=1, branch_target=0x110, m=3'b100.
3. lw: ALUSrc=1, ALUOp=00, A=0x1000, sign_ext=0xFFFFFFFC, RegDst=0, rt=8 → alu_result=0xFFC, write_reg=8, wb=2'b11, m=3'b010.
4. SLT signed: A=0xFFFFFFFF, B=1, funct=101010 → alu_result=1; swap operands → 0, zero=1.
5. Flush/stall: load valid add, then stall=1 for 2 cycles with changed inputs → outputs hold. Then flush=1 with stall=1 → wb=0, m=0, valid=0.
6. Reset: drive reset=0 during a stream → all outputs 0 after the edge. Release with an add (A=3, B=4) applied → alu_result=7 one cycle later.
